// File: rtl/regfile_bus_ctrl.sv
// Clocked front-end for the async-strobe register file: sequences CS/OE/WE and the shared data bus.
// Optional write read-back check when RFBC_VERIFY_EN is defined (adds the err port).
module regfile_bus_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
`ifdef RFBC_VERIFY_EN
  output logic                  err,
`endif
  output logic                  rf_chip_select,
  output logic                  rf_output_enable,
  output logic                  rf_write_strobe,
  output logic [ADDR_WIDTH-1:0] rf_address,
  inout  wire  [DATA_WIDTH-1:0] rf_data
);

  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_SAMPLE, DONE
`ifdef RFBC_VERIFY_EN
    , V_SETUP, V_SAMPLE
`endif
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   ready_d, done_d, cs_d, oe_d, ws_d, drv_d;
  logic   ready_q, done_q, cs_q, oe_q, ws_q, drv_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = we ? W_SETUP : R_SETUP;
        end
      end
      W_SETUP:  state_d = W_STROBE;
      W_STROBE: state_d = W_HOLD;
`ifdef RFBC_VERIFY_EN
      W_HOLD:   state_d = V_SETUP;
      V_SETUP:  state_d = V_SAMPLE;
      V_SAMPLE: state_d = DONE;
`else
      W_HOLD:   state_d = DONE;
`endif
      R_SETUP:  state_d = R_SAMPLE;
      R_SAMPLE: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Pin values are decoded from the next state and registered, so every rf_* pin is a flop output.
  always_comb begin
    ready_d = 1'b0;
    done_d  = 1'b0;
    cs_d    = 1'b0;
    oe_d    = 1'b0;
    ws_d    = 1'b0;
    drv_d   = 1'b0;
    case (state_d)
      IDLE:             begin ready_d = 1'b1; cs_d = 1'b1; end
      W_SETUP, W_HOLD:  drv_d = 1'b1;
      W_STROBE:         begin drv_d = 1'b1; ws_d = 1'b1; end
      R_SETUP, R_SAMPLE: oe_d = 1'b1;
`ifdef RFBC_VERIFY_EN
      V_SETUP, V_SAMPLE: oe_d = 1'b1;
`endif
      DONE:             begin done_d = 1'b1; cs_d = 1'b1; end
      default:          cs_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b0;
      ws_q    <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      ws_q    <= ws_d;
      drv_q   <= drv_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state_q == R_SAMPLE) rdata_q <= rf_data;
    end
  end

`ifdef RFBC_VERIFY_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err_q <= 1'b0;
    else if (accept)               err_q <= 1'b0;
    else if (state_q == V_SAMPLE)  err_q <= (rf_data != wdata_q);
  end
  assign err = err_q;
`endif

  assign ready            = ready_q;
  assign done             = done_q;
  assign rdata            = rdata_q;
  assign rf_chip_select   = cs_q;
  assign rf_output_enable = oe_q;
  assign rf_write_strobe  = ws_q;
  assign rf_address       = addr_q;
  assign rf_data          = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_regfile_bus_ctrl.sv
// Bench for regfile_bus_ctrl: behavioural register file on the bus, scoreboard of expected
// completions checked by an independent monitor, directed cases followed by random traffic.
module tb_regfile_bus_ctrl;

  logic       clk, rst_n, req, we;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       ready, done;
  logic [7:0] rdata;
`ifdef RFBC_VERIFY_EN
  logic       err;
  localparam int WR_LAT = 5;
`else
  localparam int WR_LAT = 3;
`endif
  localparam int RD_LAT = 2;
  logic       rf_chip_select, rf_output_enable, rf_write_strobe;
  logic [4:0] rf_address;
  wire  [7:0] rf_data;

  regfile_bus_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata),
`ifdef RFBC_VERIFY_EN
    .err(err),
`endif
    .rf_chip_select(rf_chip_select), .rf_output_enable(rf_output_enable),
    .rf_write_strobe(rf_write_strobe), .rf_address(rf_address), .rf_data(rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External register file: async read when selected with OE, writes on the strobe's rising edge.
  logic [7:0] rf_mem [32];
  bit         stuck0 = 1'b0;
  int         strobe_edges = 0;
  assign rf_data = (!rf_chip_select && rf_output_enable) ? rf_mem[rf_address] : 8'bz;
  always @(posedge rf_write_strobe) begin
    strobe_edges = strobe_edges + 1;
    if (!rf_chip_select) rf_mem[rf_address] <= stuck0 ? (rf_data & 8'hFE) : rf_data;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         is_wr;
    logic [7:0] data;
    int         lat;
    bit         exp_err;
    time        acc;
  } exp_t;

  exp_t       sbq [$];
  logic [7:0] ref_mem [32];
  logic [4:0] cur_addr;
  logic [7:0] cur_wdata;

  task automatic issue(input bit w, input logic [4:0] a, input logic [7:0] d, input bit junk);
    exp_t e;
    int   n;
    logic [7:0] stored;
    n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (!ready) begin chk("ready_timeout", ready, 1); return; end
    req = 1'b1; we = w; addr = a; wdata = d;
    cur_addr = a; cur_wdata = d;
    @(posedge clk);
    e.acc   = $time;
    e.is_wr = w;
    if (w) begin
      stored     = stuck0 ? (d & 8'hFE) : d;
      ref_mem[a] = stored;
      e.data     = 8'h00;
      e.lat      = WR_LAT;
`ifdef RFBC_VERIFY_EN
      e.exp_err  = (stored != d);
`else
      e.exp_err  = 1'b0;
`endif
    end else begin
      e.data    = ref_mem[a];
      e.lat     = RD_LAT;
      e.exp_err = 1'b0;
    end
    sbq.push_back(e);
    @(negedge clk);
`ifdef RFBC_VERIFY_EN
    chk("err_clear_on_accept", err, 0);
`endif
    if (junk) begin
      req = 1'b1; we = ~w; addr = a ^ 5'h15; wdata = ~d;
      repeat (3) @(negedge clk);
    end
    req = 1'b0;
  endtask

  exp_t mon_e;
  bit   done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        chk("done_single_pulse", done_prev, 0);
        if (sbq.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_latency", 32'(($time - mon_e.acc) / 10), mon_e.lat);
          if (!mon_e.is_wr) chk("rdata", rdata, mon_e.data);
`ifdef RFBC_VERIFY_EN
          chk("err_at_done", err, mon_e.exp_err);
`endif
        end
      end
      if (rf_output_enable) chk("no_strobe_while_oe", rf_write_strobe, 0);
      if (rf_output_enable && !rf_chip_select) chk("bus_read_value", rf_data, rf_mem[rf_address]);
      if (!rf_chip_select && !rf_output_enable) begin
        chk("wr_addr_stable", rf_address, cur_addr);
        chk("wr_data_stable", rf_data, cur_wdata);
      end
    end
    done_prev = done;
  end

  initial begin
    int n;
    int edges_before;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cs", rf_chip_select, 1);
    chk("rst_oe", rf_output_enable, 0);
    chk("rst_ws", rf_write_strobe, 0);
    chk("rst_addr", rf_address, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(1'b1, 5'd3, 8'hA5, 1'b0);
    issue(1'b0, 5'd3, 8'h00, 1'b0);

    issue(1'b1, 5'd0,  8'h11, 1'b0);
    issue(1'b1, 5'd31, 8'h22, 1'b0);
    issue(1'b0, 5'd0,  8'h00, 1'b0);
    issue(1'b0, 5'd31, 8'h00, 1'b0);

    issue(1'b1, 5'd7, 8'h5A, 1'b1);
    issue(1'b0, 5'd7, 8'h00, 1'b0);
    issue(1'b0, 5'd7 ^ 5'h15, 8'h00, 1'b0);

    // Reset while the strobe is high: the write edge has already happened, nothing further may.
    n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    req = 1'b1; we = 1'b1; addr = 5'd9; wdata = 8'h3C;
    cur_addr = 5'd9; cur_wdata = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #2;
    chk("strobe_high_before_reset", rf_write_strobe, 1);
    ref_mem[9] = 8'h3C;
    edges_before = strobe_edges;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_cs", rf_chip_select, 1);
    chk("midrst_oe", rf_output_enable, 0);
    chk("midrst_ws", rf_write_strobe, 0);
    chk("midrst_addr", rf_address, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_no_strobe_edge", strobe_edges, edges_before);
    issue(1'b0, 5'd9, 8'h00, 1'b0);

`ifdef RFBC_VERIFY_EN
    stuck0 = 1'b1;
    issue(1'b1, 5'd5, 8'h01, 1'b0);
    issue(1'b0, 5'd5, 8'h00, 1'b0);
    stuck0 = 1'b0;
`endif

    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (sbq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("scoreboard_drained", sbq.size(), 0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
